// File: rtl/bn_sched.sv
// Batch-norm scheduler: feeds one vector at a time through an external fixed-latency
// datapath and owns the gamma/beta registers. Optional stall counter: BN_SCHED_STALL_CNT_EN.
module bn_sched #(
  parameter int unsigned SIZE       = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned LATENCY    = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [7:0]                   batch_len,
  output logic                         busy,
  output logic                         done,
  input  logic                         cfg_we,
  input  logic                         cfg_sel,
  input  logic [15:0]                  cfg_wdata,
  output logic                         cfg_err,
`ifdef BN_SCHED_STALL_CNT_EN
  output logic [15:0]                  stall_cnt,
`endif
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [SIZE*DATA_WIDTH-1:0]   s_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [SIZE*DATA_WIDTH-1:0]   m_data,
  output logic [SIZE*DATA_WIDTH-1:0]   dp_x,
  input  logic [SIZE*DATA_WIDTH-1:0]   dp_out,
  output logic [15:0]                  dp_gamma,
  output logic [15:0]                  dp_beta
);

  localparam int unsigned VW = SIZE * DATA_WIDTH;
  localparam logic [3:0]  LAT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT
  } state_e;

  state_e          state_q;
  logic            busy_q;
  logic            s_ready_q;
  logic            m_valid_q;
  logic            done_q;
  logic            cfg_err_q;
  logic [7:0]      len_q;
  logic [7:0]      vec_cnt_q;
  logic [3:0]      lat_cnt_q;
  logic [VW-1:0]   dp_x_q;
  logic [VW-1:0]   m_data_q;
  logic [15:0]     gamma_q;
  logic [15:0]     beta_q;
`ifdef BN_SCHED_STALL_CNT_EN
  logic [15:0]     stall_cnt_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      s_ready_q   <= 1'b0;
      m_valid_q   <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      len_q       <= '0;
      vec_cnt_q   <= '0;
      lat_cnt_q   <= '0;
      dp_x_q      <= '0;
      m_data_q    <= '0;
      gamma_q     <= 16'h3C00;
      beta_q      <= '0;
`ifdef BN_SCHED_STALL_CNT_EN
      stall_cnt_q <= '0;
`endif
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;

      // Coefficients may only change between batches so a batch sees one gamma/beta.
      if (cfg_we) begin
        if (state_q == ST_IDLE) begin
          if (cfg_sel) beta_q  <= cfg_wdata;
          else         gamma_q <= cfg_wdata;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (start) begin
`ifdef BN_SCHED_STALL_CNT_EN
            stall_cnt_q <= '0;
`endif
            if (batch_len != 8'd0) begin
              len_q     <= batch_len;
              vec_cnt_q <= '0;
              busy_q    <= 1'b1;
              s_ready_q <= 1'b1;
              state_q   <= ST_ISSUE;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          if (s_valid) begin
            dp_x_q    <= s_data;
            lat_cnt_q <= LAT_LOAD;
            s_ready_q <= 1'b0;
            state_q   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (lat_cnt_q == 4'd0) begin
            m_data_q  <= dp_out;
            m_valid_q <= 1'b1;
            state_q   <= ST_OUT;
          end else begin
            lat_cnt_q <= lat_cnt_q - 4'd1;
          end
        end
        ST_OUT: begin
          if (m_ready) begin
            m_valid_q <= 1'b0;
            if (vec_cnt_q == len_q - 8'd1) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              vec_cnt_q <= vec_cnt_q + 8'd1;
              s_ready_q <= 1'b1;
              state_q   <= ST_ISSUE;
            end
          end
`ifdef BN_SCHED_STALL_CNT_EN
          else if (stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign cfg_err  = cfg_err_q;
  assign s_ready  = s_ready_q;
  assign m_valid  = m_valid_q;
  assign m_data   = m_data_q;
  assign dp_x     = dp_x_q;
  assign dp_gamma = gamma_q;
  assign dp_beta  = beta_q;
`ifdef BN_SCHED_STALL_CNT_EN
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bn_sched.sv
// Directed bench for bn_sched with an identity datapath model (LATENCY=2).
module tb_bn_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  batch_len = '0;
  logic        busy, done, cfg_err;
  logic        cfg_we = 1'b0;
  logic        cfg_sel = 1'b0;
  logic [15:0] cfg_wdata = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [63:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [63:0] m_data, dp_x, dp_out;
  logic [15:0] dp_gamma, dp_beta;
`ifdef BN_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  bn_sched #(.SIZE(4), .DATA_WIDTH(16), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .start(start), .batch_len(batch_len),
    .busy(busy), .done(done), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
`ifdef BN_SCHED_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .dp_x(dp_x), .dp_out(dp_out), .dp_gamma(dp_gamma), .dp_beta(dp_beta)
  );

  // Identity datapath: result valid one register stage after dp_x.
  logic [63:0] dp_r = '0;
  always @(posedge clk) dp_r <= dp_x;
  assign dp_out = dp_r;

  int done_cnt = 0;
  int err_cnt  = 0;
  int busy_cnt = 0;
  always @(negedge clk) begin
    if (done)    done_cnt++;
    if (cfg_err) err_cnt++;
    if (busy)    busy_cnt++;
  end

  int n_vec = 0;
  int n_mis = 0;
  int lat_k = 0;

  typedef struct {
    logic [63:0] s;
    logic [63:0] exp_m;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({nm, "_m_valid"}, 64'(m_valid), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_cfg_err"}, 64'(cfg_err), 64'd0);
    chk({nm, "_m_data"}, m_data, 64'd0);
    chk({nm, "_dp_x"}, dp_x, 64'd0);
    chk({nm, "_gamma"}, 64'(dp_gamma), 64'h3C00);
    chk({nm, "_beta"}, 64'(dp_beta), 64'h0000);
  endtask

  task automatic do_start(input logic [7:0] n);
    start = 1'b1;
    batch_len = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the first falling edge after the s transfer.
  task automatic send(input logic [63:0] d);
    int w;
    w = 0;
    s_valid = 1'b1;
    s_data = d;
    while (!s_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!s_ready) chk("s_ready_timeout", 64'(s_ready), 64'd1);
    @(negedge clk);
    s_valid = 1'b0;
    chk("dp_x_after_transfer", dp_x, d);
    lat_k = 1;
  endtask

  task automatic recv(input logic [63:0] exp, input int hold, input bit last, input bit poke_start);
    while (!m_valid && lat_k < 40) begin
      @(negedge clk);
      lat_k++;
    end
    chk("m_valid_latency", 64'(lat_k), 64'd3);
    chk("m_data", m_data, exp);
    if (hold > 0) begin
      m_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
        if (poke_start && i == 0) begin
          start = 1'b1;
          batch_len = 8'd5;
        end
        @(negedge clk);
        start = 1'b0;
        chk("hold_m_valid", 64'(m_valid), 64'd1);
        chk("hold_m_data", m_data, exp);
        chk("hold_s_ready", 64'(s_ready), 64'd0);
      end
      m_ready = 1'b1;
    end
    @(negedge clk);
    chk("m_valid_drop", 64'(m_valid), 64'd0);
    chk("done_at_end", 64'(done), 64'(last));
    if (last) begin
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("busy_after_batch", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d0, e0, b0;
    logic [63:0] v;

    tbl[0] = '{64'h4000_4000_4000_4000, 64'h4000_4000_4000_4000};
    tbl[1] = '{64'h3C00_BC00_0000_7BFF, 64'h3C00_BC00_0000_7BFF};
    tbl[2] = '{64'h0001_8001_7C00_FC00, 64'h0001_8001_7C00_FC00};
    tbl[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    tbl[4] = '{64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000};
    tbl[5] = '{64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0};

    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk);

    // Single-vector batch, identity datapath
    d0 = done_cnt;
    do_start(8'd1);
    send(64'h4000_4000_4000_4000);
    recv(64'h4000_4000_4000_4000, 0, 1'b1, 1'b0);
    chk("single_done_count", 64'(done_cnt - d0), 64'd1);

    // Table-driven six-vector batch
    d0 = done_cnt;
    do_start(8'd6);
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].s);
      recv(tbl[i].exp_m, 0, (i == 5), 1'b0);
    end
    chk("table_done_count", 64'(done_cnt - d0), 64'd1);

    // Back-pressure on vector 2 of a 3-vector batch
    d0 = done_cnt;
    do_start(8'd3);
    for (int i = 0; i < 3; i++) begin
      send(tbl[i + 1].s);
      recv(tbl[i + 1].exp_m, (i == 1) ? 5 : 0, (i == 2), 1'b0);
    end
    chk("bp_done_count", 64'(done_cnt - d0), 64'd1);
`ifdef BN_SCHED_STALL_CNT_EN
    chk("stall_cnt", 64'(stall_cnt), 64'd5);
`endif

    // cfg write in IDLE accepted, during WAIT rejected
    e0 = err_cnt;
    cfg_we = 1'b1; cfg_sel = 1'b0; cfg_wdata = 16'h4000;
    @(negedge clk);
    cfg_we = 1'b0;
    chk("gamma_written", 64'(dp_gamma), 64'h4000);
    chk("no_err_idle_write", 64'(cfg_err), 64'd0);
    do_start(8'd1);
    send(64'h4400_4400_4400_4400);
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_wdata = 16'h3C00;
    @(negedge clk);
    lat_k++;
    cfg_we = 1'b0;
    chk("cfg_err_pulse", 64'(cfg_err), 64'd1);
    chk("beta_unchanged", 64'(dp_beta), 64'h0000);
    recv(64'h4400_4400_4400_4400, 0, 1'b1, 1'b0);
    chk("cfg_err_count", 64'(err_cnt - e0), 64'd1);
    chk("gamma_kept", 64'(dp_gamma), 64'h4000);

    // Zero-length batch
    d0 = done_cnt; b0 = busy_cnt;
    start = 1'b1; batch_len = 8'd0;
    @(negedge clk);
    start = 1'b0;
    chk("zero_len_done", 64'(done), 64'd1);
    chk("zero_len_s_ready", 64'(s_ready), 64'd0);
    @(negedge clk);
    chk("zero_len_done_drop", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    chk("zero_len_busy_never", 64'(busy_cnt - b0), 64'd0);
    chk("zero_len_done_count", 64'(done_cnt - d0), 64'd1);

    // Start during OUT is ignored
    d0 = done_cnt;
    do_start(8'd2);
    send(tbl[5].s);
    recv(tbl[5].exp_m, 3, 1'b0, 1'b1);
    send(tbl[1].s);
    recv(tbl[1].exp_m, 0, 1'b1, 1'b0);
    chk("ignored_start_done_count", 64'(done_cnt - d0), 64'd1);
    repeat (3) @(negedge clk);
    chk("ignored_start_idle", 64'(busy), 64'd0);

    // Maximum batch length
    d0 = done_cnt;
    do_start(8'd255);
    for (int i = 0; i < 255; i++) begin
      v = {8'(i), 8'h11, 8'(255 - i), 8'h22, 8'(i), 8'h33, 8'(i ^ 8'h5A), 8'h44};
      send(v);
      recv(v, 0, (i == 254), 1'b0);
    end
    chk("max_len_done_count", 64'(done_cnt - d0), 64'd1);

    // Asynchronous reset in WAIT
    d0 = done_cnt;
    do_start(8'd1);
    send(64'h5000_5000_5000_5000);
    #2 reset = 1'b0;
    #1 chk_reset_vals("async_reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_no_done", 64'(done_cnt - d0), 64'd0);
    chk("reset_m_valid_stays_low", 64'(m_valid), 64'd0);
    d0 = done_cnt;
    do_start(8'd1);
    send(64'h3800_3A00_3C00_3E00);
    recv(64'h3800_3A00_3C00_3E00, 0, 1'b1, 1'b0);
    chk("post_reset_done_count", 64'(done_cnt - d0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
